// File: rtl/rect_stream_receiver.sv
// Ping-pong batch receiver for the rect copy DMA stream: collects 16-word batches
// per phase (LEFT..COLOR) into two banks and hands them to a consumer in order.
module rect_stream_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int BATCH_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic [3:0]            rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  batch_ready,
  output logic [2:0]            batch_phase,
  output logic [1:0]            batch_index,
  input  logic                  batch_release,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_LEFT   = 3'd1;
  localparam logic [2:0] PH_RIGHT  = 3'd2;
  localparam logic [2:0] PH_TOP    = 3'd3;
  localparam logic [2:0] PH_BOTTOM = 3'd4;
  localparam logic [2:0] PH_COLOR  = 3'd5;
  localparam logic [3:0] WORD_LAST = 4'(BATCH_WORDS - 1);

  logic [2:0]            phase_r;
  logic [1:0]            batch_r;
  logic [3:0]            word_r;
  logic                  wr_bank_r;
  logic                  rd_bank_r;
  logic [1:0]            full_r;
  logic [1:0][2:0]       tag_phase_r;
  logic [1:0][1:0]       tag_index_r;
  logic                  overflow_r;
  logic                  frame_done_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  // Bank contents deliberately have no reset; only flags and counters are cleared.
  logic [DATA_WIDTH-1:0] mem_r [0:31];

  logic                  accept_s;
  logic                  drop_s;
  logic                  last_word_s;
  logic                  frame_end_s;
  logic                  release_s;
  logic [1:0]            full_next_s;
  logic [2:0]            phase_next_s;

  // Acceptance, drop, release and ping-pong flag decode for this cycle.
  always_comb begin
    accept_s     = 1'b0;
    drop_s       = 1'b0;
    last_word_s  = 1'b0;
    frame_end_s  = 1'b0;
    release_s    = batch_release && full_r[rd_bank_r];
    full_next_s  = full_r;
    phase_next_s = PH_IDLE;
    if (din_valid && (phase_r != PH_IDLE) && !frame_start) begin
      accept_s = !full_r[wr_bank_r];
      drop_s   = full_r[wr_bank_r];
    end else begin
      accept_s = 1'b0;
      drop_s   = 1'b0;
    end
    last_word_s = accept_s && (word_r == WORD_LAST);
    frame_end_s = last_word_s && (phase_r == PH_COLOR) && (batch_r == 2'd3);
    // Completion is applied after release so a batch landing in the freed bank wins.
    if (release_s) begin
      full_next_s[rd_bank_r] = 1'b0;
    end else begin
      full_next_s = full_next_s;
    end
    if (last_word_s) begin
      full_next_s[wr_bank_r] = 1'b1;
    end else begin
      full_next_s = full_next_s;
    end
    case (phase_r)
      PH_LEFT:   phase_next_s = PH_RIGHT;
      PH_RIGHT:  phase_next_s = PH_TOP;
      PH_TOP:    phase_next_s = PH_BOTTOM;
      PH_BOTTOM: phase_next_s = PH_COLOR;
      PH_COLOR:  phase_next_s = PH_IDLE;
      default:   phase_next_s = PH_IDLE;
    endcase
  end

  // Receiver counters, bank flags/tags and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r      <= PH_IDLE;
      batch_r      <= 2'd0;
      word_r       <= 4'd0;
      wr_bank_r    <= 1'b0;
      rd_bank_r    <= 1'b0;
      full_r       <= 2'b00;
      tag_phase_r  <= '0;
      tag_index_r  <= '0;
      overflow_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else if (frame_start) begin
      phase_r      <= PH_LEFT;
      batch_r      <= 2'd0;
      word_r       <= 4'd0;
      wr_bank_r    <= 1'b0;
      rd_bank_r    <= 1'b0;
      full_r       <= 2'b00;
      overflow_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= frame_end_s;
      full_r       <= full_next_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (release_s) begin
        rd_bank_r <= ~rd_bank_r;
      end
      if (accept_s) begin
        word_r <= word_r + 4'd1;
        if (last_word_s) begin
          tag_phase_r[wr_bank_r] <= phase_r;
          tag_index_r[wr_bank_r] <= batch_r;
          wr_bank_r              <= ~wr_bank_r;
          word_r                 <= 4'd0;
          if (batch_r == 2'd3) begin
            batch_r <= 2'd0;
            phase_r <= phase_next_s;
          end else begin
            batch_r <= batch_r + 2'd1;
          end
        end
      end
    end
  end

  // Bank write port.
  always_ff @(posedge clk) begin
    if (accept_s && !reset) begin
      mem_r[{wr_bank_r, word_r}] <= din;
    end
  end

  // Registered read port on the consumer-facing bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= '0;
    end else begin
      rd_data_r <= mem_r[{rd_bank_r, rd_idx}];
    end
  end

  assign rd_data     = rd_data_r;
  assign batch_ready = full_r[rd_bank_r];
  assign batch_phase = full_r[rd_bank_r] ? tag_phase_r[rd_bank_r] : 3'd0;
  assign batch_index = full_r[rd_bank_r] ? tag_index_r[rd_bank_r] : 2'd0;
  assign frame_done  = frame_done_r;
  assign overflow    = overflow_r;

endmodule

// File: doc/rect_stream_receiver.md
RECT_STREAM_RECEIVER -- requirements
Module: rect_stream_receiver

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of every stream word and buffer entry.
REQ-002 Parameter BATCH_WORDS, default 16, words per batch (rectangles per batch); fixed at 16 for this design.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle pulse; begins reception of a new frame (driven alongside the DMA copy_start).
REQ-006 din  input  DATA_WIDTH  stream word from the rect copy DMA (clamped coordinate or color).
REQ-007 din_valid  input  1  din carries a new word this cycle.
REQ-008 rd_idx  input  4  entry index to read from the current ready batch.
REQ-009 rd_data  output  DATA_WIDTH  registered read data of entry rd_idx.
REQ-010 batch_ready  output  1  a complete batch is held for the consumer.
REQ-011 batch_phase  output  3  tag of ready batch: 1=LEFT, 2=RIGHT, 3=TOP, 4=BOTTOM, 5=COLOR.
REQ-012 batch_index  output  2  tag of ready batch: batch number 0..3 within its phase.
REQ-013 batch_release  input  1  one-cycle pulse; consumer finished with the ready batch.
REQ-014 frame_done  output  1  one-cycle pulse; last word of frame (COLOR, batch 3, word 15) captured.
REQ-015 overflow  output  1  sticky; a word arrived while no bank was free.

Function
REQ-016 Storage SHALL be two banks (ping-pong) of 16 x DATA_WIDTH, each with a full flag and phase/index tags.
REQ-017 Receiver state SHALL be IDLE (phase 0) or RECEIVING (phase 1..5); din_valid in IDLE is ignored.
REQ-018 frame_start SHALL, next cycle: phase=LEFT, batch=0, word=0, wr_bank=0, rd_bank=0, both full flags=0, overflow=0; din_valid in the frame_start cycle is ignored; valid in any state, including mid-frame.
REQ-019 Each accepted word (din_valid, RECEIVING, full[wr_bank]=0) SHALL be written to bank[wr_bank][word]; word increments.
REQ-020 On accepting word 15: full[wr_bank]<=1, tags<= current phase/batch, wr_bank toggles, word<=0, batch increments; on batch 3 wrap, batch<=0 and phase increments.
REQ-021 Accepting word 15 of COLOR batch 3 SHALL pulse frame_done the following cycle and return to IDLE.
REQ-022 din_valid while full[wr_bank]=1 SHALL drop the word, leave counters unchanged, and set overflow until reset or frame_start.
REQ-023 batch_ready SHALL equal full[rd_bank]; batch_phase/batch_index SHALL show rd_bank tags, 0 when not ready.
REQ-024 batch_release with batch_ready=1 SHALL clear full[rd_bank] and toggle rd_bank next cycle; release with batch_ready=0 is ignored.
REQ-025 Release and batch completion in the same cycle SHALL both take effect (different or same bank, ready flag reflects net result: completion into freed bank sets it full).
REQ-026 rd_data SHALL be bank[rd_bank][rd_idx] sampled at posedge, one-cycle latency, independent of batch_ready.
REQ-027 Batches SHALL be presented in arrival order; ordering across phases is LEFT, RIGHT, TOP, BOTTOM, COLOR, batches 0..3 each (20 batches/frame).
REQ-028 Bank contents are not cleared by frame_start or reset; only flags and counters are.

Reset
REQ-029 On reset: IDLE, counters 0, wr_bank=rd_bank=0, full flags 0, rd_data=0, batch_ready=0, batch_phase=0, batch_index=0, frame_done=0, overflow=0.
REQ-030 Reset SHALL take priority over frame_start, din_valid and batch_release in the same cycle.

Verification
REQ-031 frame_start, 16 words 100..115 at 1 word/3 cycles -> batch_ready=1, phase=1, index=0; rd_idx=5 -> rd_data=105 next cycle.
REQ-032 Full frame (320 words), consumer releases each batch within 600 cycles -> 20 batches in order, frame_done once after word 320, overflow=0.
REQ-033 No releases, 48 words -> two banks full, words 33..48 dropped, overflow=1; frame_start -> overflow=0, batch_ready=0.
REQ-034 batch_release on same cycle as word 15 of next batch -> ready stays 1 with new tags, no word lost.
REQ-035 Reset asserted mid-batch (word 7) with din_valid=1 -> all outputs reset values next cycle; subsequent din_valid ignored until frame_start.
REQ-036 din_valid in IDLE and batch_release with batch_ready=0 -> no state change.
